// File: rtl/ps2_host_tx.sv
// ============================================================================
// Module   : ps2_host_tx
// Purpose  : PS/2 host-to-device byte transmitter (open-drain via output enables)
// Option   : PS2_TX_RETRY_EN - retry a failed frame once before reporting error
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       kClock,
   input  logic       kData,
   input  logic [7:0] data_in,
   input  logic       send,
   output logic       kClock_oe,
   output logic       kData_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       timeout
);

   localparam int c_CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
   localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1) + 1;
   localparam logic [c_CNT_W-1:0] c_INH_LAST = c_CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef PS2_TX_RETRY_EN
   localparam logic c_RETRY_EN = 1'b1;
`else
   localparam logic c_RETRY_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_INHIBIT  = 3'd1,
      S_START    = 3'd2,
      S_SEND     = 3'd3,
      S_WAIT_REL = 3'd4
   } state_t;

   state_t             r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic [3:0]         r_bitidx;
   logic [7:0]         r_shift;
   logic               r_parity;
   logic               r_retried;

   logic r_kclk_s1, r_kclk_s2, r_kclk_prev;
   logic r_kdat_s1, r_kdat_s2;

   logic w_fe;
   logic w_released;
   logic w_ack_fail;
   logic w_to_fail;
   logic w_fail;
   logic w_retry;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_kclk_s1   <= 1'b1;
         r_kclk_s2   <= 1'b1;
         r_kclk_prev <= 1'b1;
         r_kdat_s1   <= 1'b1;
         r_kdat_s2   <= 1'b1;
      end else begin
         r_kclk_s1   <= kClock;
         r_kclk_s2   <= r_kclk_s1;
         r_kclk_prev <= r_kclk_s2;
         r_kdat_s1   <= kData;
         r_kdat_s2   <= r_kdat_s1;
      end
   end

   always_comb begin
      w_fe       = r_kclk_prev & ~r_kclk_s2;
      w_released = r_kclk_s2 & r_kdat_s2;
      w_ack_fail = (r_state == S_SEND) && w_fe && (r_bitidx == 4'd10) && r_kdat_s2;
      // The stall counter only matters while the device owns the clock.
      w_to_fail  = (r_cnt == c_TO_LAST) && !w_fe &&
                   ((r_state == S_SEND) || ((r_state == S_WAIT_REL) && !w_released));
      w_fail     = w_ack_fail | w_to_fail;
      w_retry    = c_RETRY_EN & ~r_retried;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bitidx  <= '0;
         r_shift   <= '0;
         r_parity  <= 1'b0;
         r_retried <= 1'b0;
         kClock_oe <= 1'b0;
         kData_oe  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ack_err   <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         done    <= 1'b0;
         ack_err <= 1'b0;
         timeout <= 1'b0;

         case (r_state)
            S_IDLE: begin
               kClock_oe <= 1'b0;
               kData_oe  <= 1'b0;
               busy      <= 1'b0;
               if (send) begin
                  r_shift   <= data_in;
                  r_parity  <= ~^data_in;
                  r_cnt     <= '0;
                  r_retried <= 1'b0;
                  kClock_oe <= 1'b1;
                  busy      <= 1'b1;
                  r_state   <= S_INHIBIT;
               end
            end

            S_INHIBIT: begin
               if (r_cnt == c_INH_LAST) begin
                  r_cnt    <= '0;
                  kData_oe <= 1'b1;
                  r_state  <= S_START;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            S_START: begin
               kClock_oe <= 1'b0;
               r_bitidx  <= '0;
               r_cnt     <= '0;
               r_state   <= S_SEND;
            end

            S_SEND: begin
               if (w_fe) begin
                  r_cnt    <= '0;
                  r_bitidx <= r_bitidx + 1'b1;
                  if (r_bitidx < 4'd8) begin
                     kData_oe <= ~r_shift[r_bitidx[2:0]];
                  end else if (r_bitidx == 4'd8) begin
                     kData_oe <= ~r_parity;
                  end else if (r_bitidx == 4'd9) begin
                     kData_oe <= 1'b0;
                  end else if (!r_kdat_s2) begin
                     r_state <= S_WAIT_REL;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            S_WAIT_REL: begin
               if (w_released) begin
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= S_IDLE;
               end else if (w_fe) begin
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            default: begin
               kClock_oe <= 1'b0;
               kData_oe  <= 1'b0;
               busy      <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase

         // Failure handling overrides whatever the state branch scheduled.
         if (w_fail) begin
            if (w_retry) begin
               r_retried <= 1'b1;
               r_cnt     <= '0;
               kClock_oe <= 1'b1;
               kData_oe  <= 1'b0;
               r_state   <= S_INHIBIT;
            end else begin
               kClock_oe <= 1'b0;
               kData_oe  <= 1'b0;
               busy      <= 1'b0;
               ack_err   <= w_ack_fail;
               timeout   <= w_to_fail;
               r_state   <= S_IDLE;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// ============================================================================
// Module   : tb_ps2_host_tx
// Purpose  : Scoreboard bench for ps2_host_tx with a PS/2 device line model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_host_tx;

   localparam int c_INH = 200;
   localparam int c_TO  = 1000;
   localparam int c_H   = 20;

   localparam int K_DONE = 0;
   localparam int K_ACK  = 1;
   localparam int K_TO   = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       send;
   logic [7:0] data_in;
   logic       dev_cl = 1'b0;
   logic       dev_dl = 1'b0;
   logic       kClock, kData;
   logic       kClock_oe, kData_oe, busy, done, ack_err, timeout;

   assign kClock = ~(kClock_oe | dev_cl);
   assign kData  = ~(kData_oe | dev_dl);

   always #5 clk = ~clk;

   ps2_host_tx #(
      .INHIBIT_CYCLES(c_INH),
      .TIMEOUT_CYCLES(c_TO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .kClock   (kClock),
      .kData    (kData),
      .data_in  (data_in),
      .send     (send),
      .kClock_oe(kClock_oe),
      .kData_oe (kData_oe),
      .busy     (busy),
      .done     (done),
      .ack_err  (ack_err),
      .timeout  (timeout)
   );

   typedef struct {
      int          kind;
      logic [10:0] frame;
      bit          chk_frame;
   } exp_t;

   exp_t        sb[$];
   logic [10:0] cap;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_resp(input int kind, input logic [10:0] frame, input bit chkf);
      exp_t e;
      e.kind      = kind;
      e.frame     = frame;
      e.chk_frame = chkf;
      sb.push_back(e);
   endtask

   // Monitor: every result pulse is matched against the oldest expectation.
   int   mon_kind;
   int   mon_n;
   exp_t mon_e;
   always @(negedge clk) begin
      if (!rst && (done || ack_err || timeout)) begin
         mon_n = int'(done) + int'(ack_err) + int'(timeout);
         chk("pulse_exclusive", mon_n, 1);
         chk("busy_at_pulse", {31'd0, busy}, 0);
         chk("lines_released", {30'd0, kClock_oe, kData_oe}, 0);
         mon_kind = done ? K_DONE : (ack_err ? K_ACK : K_TO);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got kind %0d expected none", mon_kind);
         end else begin
            mon_e = sb.pop_front();
            chk("result_kind", mon_kind, mon_e.kind);
            if (mon_e.chk_frame) chk("frame_bits", {21'd0, cap}, {21'd0, mon_e.frame});
         end
      end
   end

   task automatic start_send(input logic [7:0] b);
      data_in = b;
      send    = 1'b1;
      @(negedge clk);
      send    = 1'b0;
   endtask

   // Device model: waits for request-to-send, then clocks nclk falling edges.
   task automatic dev_frame(input int nclk, input bit ack, input bit chk_inh);
      int n;
      cap = '0;
      n = 0;
      while (!kClock_oe && n < 5000) begin @(negedge clk); n++; end
      if (!kClock_oe) begin
         checks++; errors++;
         $display("FAIL no_inhibit: got kClock_oe 0 expected 1");
         return;
      end
      n = 0;
      while (kClock_oe && !kData_oe && n < c_INH + 100) begin @(negedge clk); n++; end
      if (chk_inh) begin
         chk("inhibit_len", n, c_INH);
         chk("start_both_oe", {30'd0, kClock_oe, kData_oe}, 32'd3);
      end
      n = 0;
      while (kClock_oe && n < 100) begin @(negedge clk); n++; end
      cap[0] = kData;
      for (int i = 1; i <= nclk; i++) begin
         repeat (c_H) @(negedge clk);
         if (i == 11 && ack) dev_dl = 1'b1;
         dev_cl = 1'b1;
         repeat (c_H) @(negedge clk);
         dev_cl = 1'b0;
         if (i <= 10) cap[i] = kData;
      end
      if (nclk == 11 && ack) begin
         repeat (c_H) @(negedge clk);
         dev_dl = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((sb.size() != 0 || busy) && n < 20000) begin @(negedge clk); n++; end
      chk("idle_reached", {31'd0, (sb.size() == 0 && !busy)}, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst     = 1'b1;
      send    = 1'b0;
      data_in = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {26'd0, kClock_oe, kData_oe, busy, done, ack_err, timeout}, 0);
      rst = 1'b0;
      @(negedge clk);

      // 0xED with ACK
      expect_resp(K_DONE, 11'b11111011010, 1'b1);
      start_send(8'hED);
      dev_frame(11, 1'b1, 1'b1);
      wait_idle();

      // Parity corners
      expect_resp(K_DONE, 11'b11000000000, 1'b1);
      start_send(8'h00);
      dev_frame(11, 1'b1, 1'b1);
      wait_idle();
      expect_resp(K_DONE, 11'b10000000010, 1'b1);
      start_send(8'h01);
      dev_frame(11, 1'b1, 1'b1);
      wait_idle();

      // send while busy is ignored
      expect_resp(K_DONE, 11'b11111011010, 1'b1);
      start_send(8'hED);
      fork
         dev_frame(11, 1'b1, 1'b1);
         begin
            repeat (50) @(negedge clk);
            start_send(8'h55);
         end
      join
      wait_idle();

      // No ACK from the device
      expect_resp(K_ACK, 11'b10000000010, 1'b1);
      start_send(8'h01);
      dev_frame(11, 1'b0, 1'b1);
`ifdef PS2_TX_RETRY_EN
      dev_frame(11, 1'b0, 1'b0);
`endif
      wait_idle();

      // Device stops clocking after the 4th falling edge
      expect_resp(K_TO, 11'd0, 1'b0);
      start_send(8'hA5);
      dev_frame(4, 1'b0, 1'b1);
`ifdef PS2_TX_RETRY_EN
      dev_frame(4, 1'b0, 1'b1);
`endif
      n = 0;
      while (!timeout && n < c_TO + 100) begin @(negedge clk); n++; end
      // Last fall was c_H cycles before n started; allow 2-3 cycles of edge detection.
      chk("timeout_latency_ok",
          {31'd0, (n + c_H >= c_TO + 2) && (n + c_H <= c_TO + 4)}, 1);
      wait_idle();

      // Reset during SEND after the 5th falling edge, then a clean 0xFF frame
      start_send(8'h3C);
      dev_frame(5, 1'b0, 1'b1);
      chk("busy_before_rst", {31'd0, busy}, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_release", {29'd0, kClock_oe, kData_oe, busy}, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      expect_resp(K_DONE, 11'b11111111110, 1'b1);
      start_send(8'hFF);
      dev_frame(11, 1'b1, 1'b1);
      wait_idle();

      repeat (50) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
